// File: rtl/queue_param.sv
// rtl/queue_param.sv - parametrised synchronous FIFO with thresholds, flush, sticky errors and selectable read mode
module queue_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_BIT  = 3,
    parameter int AF_TH      = 6,
    parameter int AE_TH      = 1,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] buf_in,
    input  logic                  rd_en,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] buf_out,
    output logic                  valid_output,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DEPTH_BIT:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                   LP_ENTRIES = 1 << DEPTH_BIT;
    localparam logic [DEPTH_BIT:0]   LP_DEPTH   = {1'b1, {DEPTH_BIT{1'b0}}};
    localparam logic [DEPTH_BIT:0]   LP_AF      = AF_TH[DEPTH_BIT:0];
    localparam logic [DEPTH_BIT:0]   LP_AE      = AE_TH[DEPTH_BIT:0];
    localparam logic [DEPTH_BIT-1:0] LP_IDX_ONE = 1;
    localparam logic [DEPTH_BIT:0]   LP_CNT_ONE = 1;

    logic [DATA_WIDTH-1:0] r_mem [0:LP_ENTRIES-1];
    logic [DEPTH_BIT-1:0]  r_wr_idx;
    logic [DEPTH_BIT-1:0]  r_rd_idx;
    logic [DEPTH_BIT:0]    r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_ovf_evt;
    logic                  w_unf_evt;

    // Status flags are decoded straight from the registered occupancy
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == LP_DEPTH);
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (r_count >= LP_AF);
    assign almost_empty = (r_count <= LP_AE);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A full queue can still take a write when a pop frees a slot in the same cycle
    assign w_rd_ok   = rd_en & ~w_empty;
    assign w_wr_ok   = wr_en & (~w_full | w_rd_ok);
    // Flush wins over both requests
    assign w_rd_acc  = w_rd_ok & ~flush;
    assign w_wr_acc  = w_wr_ok & ~flush;
    assign w_ovf_evt = wr_en & w_full & ~w_rd_ok;
    assign w_unf_evt = rd_en & w_empty;

    // Storage array, deliberately not reset
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_idx] <= buf_in;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_idx <= r_wr_idx + LP_IDX_ONE;
            end
            if (w_rd_acc) begin
                r_rd_idx <= r_rd_idx + LP_IDX_ONE;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a fresh event beats a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_evt) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry is presented combinationally whenever something is queued
            assign buf_out      = w_empty ? '0 : r_mem[r_rd_idx];
            assign valid_output = ~w_empty;
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_buf_out;
            logic                  r_valid;

            // Registered read: data lands one cycle after the accepted pop and is flagged for one cycle
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_buf_out <= '0;
                    r_valid   <= 1'b0;
                end else begin
                    r_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_buf_out <= r_mem[r_rd_idx];
                    end
                end
            end

            assign buf_out      = r_buf_out;
            assign valid_output = r_valid;
        end
    endgenerate

endmodule

// File: tb/tb_queue_param.sv
// tb/tb_queue_param.sv - directed self-checking bench for queue_param in both read modes
module tb_queue_param;

    logic        clk;
    logic        rst;

    logic        flush, wr_en, rd_en, err_clr;
    logic [31:0] buf_in;
    logic [31:0] buf_out;
    logic        valid_output, empty, full, almost_full, almost_empty, overflow, underflow;
    logic [3:0]  count;

    logic        f_flush, f_wr_en, f_rd_en, f_err_clr;
    logic [31:0] f_buf_in;
    logic [31:0] f_buf_out;
    logic        f_valid, f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
    logic [3:0]  f_count;

    int n_pass;
    int n_total;

    queue_param #(.DATA_WIDTH(32), .DEPTH_BIT(3), .AF_TH(6), .AE_TH(1), .FWFT(0)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .buf_in(buf_in),
        .rd_en(rd_en), .err_clr(err_clr), .buf_out(buf_out), .valid_output(valid_output),
        .empty(empty), .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    queue_param #(.DATA_WIDTH(32), .DEPTH_BIT(3), .AF_TH(6), .AE_TH(1), .FWFT(1)) u_dut_fwft (
        .clk(clk), .rst(rst), .flush(f_flush), .wr_en(f_wr_en), .buf_in(f_buf_in),
        .rd_en(f_rd_en), .err_clr(f_err_clr), .buf_out(f_buf_out), .valid_output(f_valid),
        .empty(f_empty), .full(f_full), .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_af", {31'd0, almost_full}, 32'd0);
        chk("rst_ae", {31'd0, almost_empty}, 32'd1);
        chk("rst_valid", {31'd0, valid_output}, 32'd0);
        chk("rst_buf_out", buf_out, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_unf", {31'd0, underflow}, 32'd0);
        chk("rst_fwft_valid", {31'd0, f_valid}, 32'd0);
        chk("rst_fwft_buf_out", f_buf_out, 32'd0);
        rst = 1'b1;
        step();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            wr_en  = 1'b1;
            buf_in = 32'h10 + 32'(i);
            step();
            chk("fill_count", {28'd0, count}, 32'(i + 1));
            chk("fill_af", {31'd0, almost_full}, {31'd0, (i + 1) >= 6});
            chk("fill_full", {31'd0, full}, {31'd0, (i + 1) == 8});
            chk("fill_ae", {31'd0, almost_empty}, {31'd0, (i + 1) <= 1});
        end
        buf_in = 32'h99;
        step();
        wr_en = 1'b0;
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_count", {28'd0, count}, 32'd8);
    endtask

    task automatic test_drain_registered();
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            step();
            chk("drain_valid", {31'd0, valid_output}, 32'd1);
            chk("drain_data", buf_out, 32'h10 + 32'(i));
            chk("drain_count", {28'd0, count}, 32'(7 - i));
        end
        rd_en = 1'b0;
        step();
        chk("drain_valid_drop", {31'd0, valid_output}, 32'd0);
        chk("drain_hold", buf_out, 32'h17);
        chk("drain_empty", {31'd0, empty}, 32'd1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("unf_set", {31'd0, underflow}, 32'd1);
        chk("unf_valid", {31'd0, valid_output}, 32'd0);
        chk("unf_count", {28'd0, count}, 32'd0);
    endtask

    task automatic test_wrap_simul();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_ovf", {31'd0, overflow}, 32'd0);
        chk("clr_unf", {31'd0, underflow}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            wr_en  = 1'b1;
            buf_in = 32'h20 + 32'(i);
            step();
        end
        chk("wrap_full", {31'd0, full}, 32'd1);
        rd_en  = 1'b1;
        buf_in = 32'hAA;
        step();
        wr_en = 1'b0;
        chk("simul_count", {28'd0, count}, 32'd8);
        chk("simul_no_ovf", {31'd0, overflow}, 32'd0);
        chk("simul_data", buf_out, 32'h20);
        for (int i = 1; i < 9; i++) begin
            step();
            chk("wrap_data", buf_out, (i == 8) ? 32'hAA : 32'h20 + 32'(i));
            chk("wrap_valid", {31'd0, valid_output}, 32'd1);
        end
        rd_en = 1'b0;
        step();
        chk("wrap_empty", {31'd0, empty}, 32'd1);
    endtask

    task automatic test_flush();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("fl_unf_pre", {31'd0, underflow}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            wr_en  = 1'b1;
            buf_in = 32'h30 + 32'(i);
            step();
        end
        chk("fl_count5", {28'd0, count}, 32'd5);
        flush  = 1'b1;
        buf_in = 32'h77;
        step();
        flush = 1'b0;
        wr_en = 1'b0;
        chk("fl_count", {28'd0, count}, 32'd0);
        chk("fl_empty", {31'd0, empty}, 32'd1);
        chk("fl_valid", {31'd0, valid_output}, 32'd0);
        chk("fl_unf_kept", {31'd0, underflow}, 32'd1);
        chk("fl_ovf_kept", {31'd0, overflow}, 32'd0);
        wr_en  = 1'b1;
        buf_in = 32'h41;
        step();
        wr_en = 1'b0;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("fl_after_data", buf_out, 32'h41);
        chk("fl_after_count", {28'd0, count}, 32'd0);
        err_clr = 1'b1;
        rd_en   = 1'b1;
        step();
        rd_en = 1'b0;
        chk("clr_vs_set", {31'd0, underflow}, 32'd1);
        step();
        err_clr = 1'b0;
        chk("clr_unf_final", {31'd0, underflow}, 32'd0);
        chk("clr_ovf_final", {31'd0, overflow}, 32'd0);
    endtask

    task automatic test_fwft();
        f_wr_en  = 1'b1;
        f_buf_in = 32'h5A;
        step();
        f_wr_en = 1'b0;
        chk("fwft_valid", {31'd0, f_valid}, 32'd1);
        chk("fwft_data", f_buf_out, 32'h5A);
        step();
        chk("fwft_hold", f_buf_out, 32'h5A);
        f_wr_en  = 1'b1;
        f_buf_in = 32'h5B;
        step();
        f_wr_en = 1'b0;
        chk("fwft_head", f_buf_out, 32'h5A);
        chk("fwft_count2", {28'd0, f_count}, 32'd2);
        f_rd_en = 1'b1;
        step();
        chk("fwft_next", f_buf_out, 32'h5B);
        chk("fwft_valid2", {31'd0, f_valid}, 32'd1);
        step();
        chk("fwft_valid_drop", {31'd0, f_valid}, 32'd0);
        chk("fwft_empty", {31'd0, f_empty}, 32'd1);
        step();
        f_rd_en = 1'b0;
        chk("fwft_unf", {31'd0, f_unf}, 32'd1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            wr_en  = 1'b1;
            buf_in = 32'h61 + 32'(i);
            step();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("ar_pre_valid", {31'd0, valid_output}, 32'd1);
        chk("ar_pre_data", buf_out, 32'h61);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_count", {28'd0, count}, 32'd0);
        chk("ar_empty", {31'd0, empty}, 32'd1);
        chk("ar_ae", {31'd0, almost_empty}, 32'd1);
        chk("ar_valid", {31'd0, valid_output}, 32'd0);
        chk("ar_buf_out", buf_out, 32'd0);
        chk("ar_fwft_valid", {31'd0, f_valid}, 32'd0);
        chk("ar_fwft_unf", {31'd0, f_unf}, 32'd0);
        rst = 1'b1;
        step();
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        err_clr   = 1'b0;
        buf_in    = '0;
        f_flush   = 1'b0;
        f_wr_en   = 1'b0;
        f_rd_en   = 1'b0;
        f_err_clr = 1'b0;
        f_buf_in  = '0;
        test_reset();
        test_fill();
        test_drain_registered();
        test_wrap_simul();
        test_flush();
        test_fwft();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
